fused_mac_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational fused multiply-add unit; computes R = A*B + C on unsigned (exponent, mantissa) operands.
- Operand value is man * 2^exp: unsigned integer mantissa, unsigned exponent, no bias, no sign.
- Four-stage pipeline with valid/ready handshakes on both sides, an in-order pass-through tag, and throughput of one operation per cycle.
- Sits between the operand sequencer and the result writeback buffer.

---
 rtl/fused_mac_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_fused_mac_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fused_mac_pipe.sv
// Four-stage pipelined fused multiply-add R = A*B + C on unsigned (exponent, mantissa) operands.
// Optional macro FMA_OVF_CNT_EN adds the ovf_flag / ovf_count outputs.
module fused_mac_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 24,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [EXP_W-1:0] exp_c,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  input  logic [MAN_W-1:0] man_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] man_out,
  output logic [TAG_W-1:0] out_tag
`ifdef FMA_OVF_CNT_EN
  ,
  output logic             ovf_flag,
  output logic [15:0]      ovf_count
`endif
);

  localparam int unsigned PW    = 2 * MAN_W;
  localparam int unsigned SW    = 5 * MAN_W + 1;
  localparam int unsigned SHMAX = 3 * MAN_W;
  localparam int unsigned XW    = EXP_W + $clog2(SW) + 2;

  logic r_v1, r_v2, r_v3, r_v4;
  logic w_ld1, w_ld2, w_ld3, w_ld4;

  // A stage loads when empty or when its contents move on this cycle.
  assign w_ld4     = !r_v4 || out_ready;
  assign w_ld3     = !r_v3 || w_ld4;
  assign w_ld2     = !r_v2 || w_ld3;
  assign w_ld1     = !r_v1 || w_ld2;
  assign in_ready  = w_ld1;
  assign out_valid = r_v4;

  logic [PW-1:0]    r_s1_p;
  logic [XW-1:0]    r_s1_ep, r_s1_ec;
  logic [MAN_W-1:0] r_s1_mc;
  logic [TAG_W-1:0] r_s1_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_s1_p   <= '0;
      r_s1_ep  <= '0;
      r_s1_ec  <= '0;
      r_s1_mc  <= '0;
      r_s1_tag <= '0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_p   <= PW'(man_a) * PW'(man_b);
        r_s1_ep  <= XW'(exp_a) + XW'(exp_b);
        r_s1_ec  <= XW'(exp_c);
        r_s1_mc  <= man_c;
        r_s1_tag <= in_tag;
      end
    end
  end

  logic [XW-1:0] w_d, w_emin, w_elarge, w_sh;
  logic [PW-1:0] w_large, w_small;
  logic          w_far, w_clamp;

  // Beyond SHMAX the larger term is shifted by SHMAX only and the smaller term
  // cannot reach the truncation window, so it is dropped and the base exponent
  // is raised instead; a zero larger term leaves the smaller one intact.
  always_comb begin
    w_d      = '0;
    w_emin   = '0;
    w_elarge = '0;
    w_large  = '0;
    w_small  = '0;
    if (r_s1_ep >= r_s1_ec) begin
      w_d      = r_s1_ep - r_s1_ec;
      w_emin   = r_s1_ec;
      w_elarge = r_s1_ep;
      w_large  = r_s1_p;
      w_small  = PW'(r_s1_mc);
    end else begin
      w_d      = r_s1_ec - r_s1_ep;
      w_emin   = r_s1_ep;
      w_elarge = r_s1_ec;
      w_large  = PW'(r_s1_mc);
      w_small  = r_s1_p;
    end
    w_far   = w_d > XW'(SHMAX);
    w_clamp = w_far && (w_large != '0);
    w_sh    = w_far ? XW'(SHMAX) : w_d;
  end

  logic [SW-1:0]    r_s2_big;
  logic [PW-1:0]    r_s2_small;
  logic [XW-1:0]    r_s2_base;
  logic [TAG_W-1:0] r_s2_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2       <= 1'b0;
      r_s2_big   <= '0;
      r_s2_small <= '0;
      r_s2_base  <= '0;
      r_s2_tag   <= '0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_big   <= SW'(w_large) << w_sh;
        r_s2_small <= w_clamp ? '0 : w_small;
        r_s2_base  <= w_clamp ? (w_elarge - XW'(SHMAX)) : w_emin;
        r_s2_tag   <= r_s1_tag;
      end
    end
  end

  logic [SW-1:0]    r_s3_sum;
  logic [XW-1:0]    r_s3_base;
  logic [TAG_W-1:0] r_s3_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3      <= 1'b0;
      r_s3_sum  <= '0;
      r_s3_base <= '0;
      r_s3_tag  <= '0;
    end else if (w_ld3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_s3_sum  <= r_s2_big + SW'(r_s2_small);
        r_s3_base <= r_s2_base;
        r_s3_tag  <= r_s2_tag;
      end
    end
  end

  logic [XW-1:0]    w_lead, w_e;
  logic [MAN_W-1:0] w_man;
  logic [EXP_W-1:0] w_exp;
  logic             w_ovf;

  always_comb begin
    w_lead = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (r_s3_sum[i]) w_lead = XW'(i);
    end
    w_e   = r_s3_base;
    w_man = r_s3_sum[MAN_W-1:0];
    if (w_lead >= XW'(MAN_W - 1)) begin
      w_man = MAN_W'(r_s3_sum >> (w_lead - XW'(MAN_W - 1)));
      w_e   = r_s3_base + w_lead - XW'(MAN_W - 1);
    end
    w_ovf = (r_s3_sum != '0) && (w_e > XW'({EXP_W{1'b1}}));
    w_exp = w_e[EXP_W-1:0];
    if (r_s3_sum == '0) begin
      w_exp = '0;
      w_man = '0;
    end else if (w_ovf) begin
      w_exp = '1;
      w_man = '0;
    end
  end

  logic [EXP_W-1:0] r_s4_exp;
  logic [MAN_W-1:0] r_s4_man;
  logic [TAG_W-1:0] r_s4_tag;
  logic             r_s4_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v4     <= 1'b0;
      r_s4_exp <= '0;
      r_s4_man <= '0;
      r_s4_tag <= '0;
      r_s4_ovf <= 1'b0;
    end else if (w_ld4) begin
      r_v4 <= r_v3;
      if (r_v3) begin
        r_s4_exp <= w_exp;
        r_s4_man <= w_man;
        r_s4_tag <= r_s3_tag;
        r_s4_ovf <= w_ovf;
      end
    end
  end

  assign exp_out = r_s4_exp;
  assign man_out = r_s4_man;
  assign out_tag = r_s4_tag;

`ifdef FMA_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (r_v4 && out_ready && r_s4_ovf && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_flag  = r_s4_ovf;
  assign ovf_count = r_ovf_cnt;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = r_s4_ovf;
`endif

endmodule

// File: tb/tb_fused_mac_pipe.sv
// Self-checking bench for fused_mac_pipe: exact wide-arithmetic reference model,
// per-cycle output compare, and directed literal vectors (FMA_OVF_CNT_EN aware).
module tb_fused_mac_pipe;
  localparam int EW = 8;
  localparam int MW = 24;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] exp_a = '0, exp_b = '0, exp_c = '0;
  logic [MW-1:0] man_a = '0, man_b = '0, man_c = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [EW-1:0] exp_out;
  logic [MW-1:0] man_out;
  logic [TW-1:0] out_tag;
`ifdef FMA_OVF_CNT_EN
  logic          ovf_flag;
  logic [15:0]   ovf_count;
  int            exp_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  longint cyc = 0;

  typedef struct packed {
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic [TW-1:0] t;
    logic          ovf;
  } res_t;

  res_t          expq[$];
  logic [TW-1:0] tagq[$];
  res_t          mon_r;
  res_t          pin_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fused_mac_pipe #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .exp_c(exp_c),
    .man_a(man_a), .man_b(man_b), .man_c(man_c),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .man_out(man_out), .out_tag(out_tag)
`ifdef FMA_OVF_CNT_EN
    , .ovf_flag(ovf_flag), .ovf_count(ovf_count)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Exact value of A*B + C in a 640-bit word relative to min exponent, then truncate.
  function automatic res_t model(input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                                 input logic [EW-1:0] eb, input logic [MW-1:0] mb,
                                 input logic [EW-1:0] ec, input logic [MW-1:0] mc,
                                 input logic [TW-1:0] tg);
    res_t r;
    logic [639:0] v, vs;
    longint unsigned p;
    int ep, eci, emin, lead, e;
    ep   = int'(ea) + int'(eb);
    eci  = int'(ec);
    emin = (ep < eci) ? ep : eci;
    p    = 64'(ma) * 64'(mb);
    v    = (640'(p) << (ep - emin)) + (640'(mc) << (eci - emin));
    r.t  = tg;
    r.ovf = 1'b0;
    r.e  = '0;
    r.m  = '0;
    if (v == '0) return r;
    lead = 0;
    for (int i = 0; i < 640; i++) if (v[i]) lead = i;
    if (lead >= MW - 1) begin
      vs  = v >> (lead - (MW - 1));
      r.m = vs[MW-1:0];
      e   = emin + lead - (MW - 1);
    end else begin
      r.m = v[MW-1:0];
      e   = emin;
    end
    if (e > (1 << EW) - 1) begin
      r.e = '1;
      r.m = '0;
      r.ovf = 1'b1;
    end else begin
      r.e = EW'(e);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
`ifdef FMA_OVF_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
`ifdef FMA_OVF_CNT_EN
      check("ovf_count", int'(ovf_count), exp_cnt);
`endif
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("out_unexpected_valid", int'(out_valid), 0);
        end else begin
          mon_r = expq[0];
          check("out_exp", int'(exp_out), int'(mon_r.e));
          check("out_man", int'(man_out), int'(mon_r.m));
          check("out_tag", int'(out_tag), int'(mon_r.t));
`ifdef FMA_OVF_CNT_EN
          check("out_ovf_flag", int'(ovf_flag), int'(mon_r.ovf));
`endif
          if (out_ready) begin
            void'(expq.pop_front());
            tagq.push_back(out_tag);
            n_out++;
`ifdef FMA_OVF_CNT_EN
            if (mon_r.ovf && exp_cnt < 16'hFFFF) exp_cnt++;
`endif
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(exp_a, man_a, exp_b, man_b, exp_c, man_c, in_tag));
        n_in++;
      end
    end
  end

  task automatic send(input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                      input logic [EW-1:0] eb, input logic [MW-1:0] mb,
                      input logic [EW-1:0] ec, input logic [MW-1:0] mc,
                      input logic [TW-1:0] tg);
    bit ok;
    int n;
    n = 0;
    exp_a = ea; man_a = ma; exp_b = eb; man_b = mb;
    exp_c = ec; man_c = mc; in_tag = tg;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    if (!ok) check("send_timeout", int'(ok), 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", int'(n < 300), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_exp_out", int'(exp_out), 0);
    check("rst_man_out", int'(man_out), 0);
    check("rst_out_tag", int'(out_tag), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    pin_r = model(8'd2, 24'h400000, 8'd2, 24'h400000, 8'd4, 24'h400000, 4'd3);
    check("model_basic_exp", int'(pin_r.e), 'h19);
    check("model_basic_man", int'(pin_r.m), 'h800002);
    pin_r = model(8'd200, 24'h800000, 8'd100, 24'h800000, 8'd0, 24'h0, 4'd0);
    check("model_ovf_exp", int'(pin_r.e), 'hFF);
    check("model_ovf_man", int'(pin_r.m), 0);

    @(posedge clk);
    #1;
    out_ready = 1'b1;

    send(8'd2, 24'h400000, 8'd2, 24'h400000, 8'd4, 24'h400000, 4'd3);
    wait_valid(n);
    check("basic_latency", n + 1, 4);
    check("basic_exp", int'(exp_out), 'h19);
    check("basic_man", int'(man_out), 'h800002);
    check("basic_tag", int'(out_tag), 3);
    @(posedge clk);
    #1;
    check("basic_single_beat", int'(out_valid), 0);

    send(8'd1, 24'h000000, 8'd1, 24'h800000, 8'd5, 24'h000003, 4'd1);
    wait_valid(n);
    check("zprod_exp", int'(exp_out), 2);
    check("zprod_man", int'(man_out), 'h18);

    send(8'd200, 24'h800000, 8'd100, 24'h800000, 8'd0, 24'h0, 4'd2);
    wait_valid(n);
    check("ovf_exp", int'(exp_out), 'hFF);
    check("ovf_man", int'(man_out), 0);
`ifdef FMA_OVF_CNT_EN
    check("ovf_flag_set", int'(ovf_flag), 1);
    @(posedge clk);
    #1;
    check("ovf_count_one", int'(ovf_count), 1);
`endif

    send(8'd7, 24'h0, 8'd9, 24'h5, 8'd3, 24'h0, 4'd4);
    wait_valid(n);
    check("zero_sum_exp", int'(exp_out), 0);
    check("zero_sum_man", int'(man_out), 0);

    send(8'd200, 24'h0, 8'd50, 24'h0, 8'd0, 24'h5, 4'd5);
    wait_valid(n);
    check("far_zero_large_exp", int'(exp_out), 0);
    check("far_zero_large_man", int'(man_out), 5);

    send(8'd100, 24'h1, 8'd0, 24'h1, 8'd0, 24'h7, 4'd6);
    wait_valid(n);
    check("far_drop_exp", int'(exp_out), 77);
    check("far_drop_man", int'(man_out), 'h800000);
    drain();

    // Backpressure: four held, then in_ready drops; release delivers all in order.
    t0 = n_in;
    tagq.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'(i * 5), 24'(32'h00ABCDEF ^ (i * 32'h00111111)), 8'(20 + i),
               24'(32'h00800001 + i), 8'(i * 9), 24'(32'h00001234 * (i + 1)), 4'(i));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_held_count", n_in - t0, 4);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_head_tag", int'(out_tag), 0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", tagq.size(), 8);
    for (int i = 0; i < 8 && i < tagq.size(); i++)
      check("bp_order", int'(tagq[i]), i);

    t0 = int'(cyc);
    for (int i = 0; i < 16; i++)
      send(8'(i), 24'(32'h00F00000 + i), 8'(3 * i), 24'(32'h00345678 - i), 8'(40 - i), 24'(i * 77), 4'(i));
    check("tput_cycles", int'(cyc) - t0, 16);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(8'(i + 1), 24'(32'h00C00000 + i), 8'd10, 24'h9ABCDE, 8'(30 + i), 24'h00FFFF, 4'(i + 8));
    check("full_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    t0 = int'(cyc);
    for (int i = 0; i < 8; i++)
      send(8'(i * 2), 24'(32'h00700000 + i * 3), 8'd5, 24'h800000, 8'd12, 24'(i), 4'(i));
    check("full_rate_cycles", int'(cyc) - t0, 8);
    drain();

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < 3; i++)
      send(8'd10, 24'(32'h00400000 + i), 8'd10, 24'h400000, 8'd20, 24'h1, 4'(i + 1));
    @(posedge clk);
    #1;
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_exp", int'(exp_out), 0);
    check("async_rst_man", int'(man_out), 0);
    check("async_rst_tag", int'(out_tag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_out", int'(out_valid), 0);
    end
    send(8'd2, 24'h400000, 8'd2, 24'h400000, 8'd4, 24'h400000, 4'd9);
    wait_valid(n);
    check("post_rst_latency", n + 1, 4);
    check("post_rst_man", int'(man_out), 'h800002);
    check("post_rst_tag", int'(out_tag), 9);
    drain();

    begin
      bit done;
      done = 1'b0;
      fork
        begin
          logic [EW-1:0] ea, eb, ec;
          logic [MW-1:0] ma, mb, mc;
          for (int i = 0; i < 10000; i++) begin
            ea = ($urandom_range(0, 3) == 0) ? EW'($urandom) : EW'($urandom_range(0, 100));
            eb = ($urandom_range(0, 3) == 0) ? EW'($urandom) : EW'($urandom_range(0, 100));
            ec = EW'($urandom);
            case ($urandom_range(0, 4))
              0: ma = '0;
              1: ma = MW'($urandom_range(1, 15));
              default: ma = MW'($urandom);
            endcase
            case ($urandom_range(0, 4))
              0: mb = '0;
              1: mb = MW'($urandom_range(1, 15));
              default: mb = MW'($urandom);
            endcase
            case ($urandom_range(0, 4))
              0: mc = '0;
              1: mc = MW'($urandom_range(1, 15));
              default: mc = MW'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            send(ea, ma, eb, mb, ec, mc, TW'(i));
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
          end
        end
      join
    end
    out_ready = 1'b1;
    drain();
    check("final_queue_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
